// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage ARM core.
// Owns the PC, freezes on hazards, flushes on taken branches, counts stalls/flushes.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [ADDR_W-1:0]  pc_q, pc_d, pcPlus;
    logic [ADDR_W-1:0]  ifIdPc_q, ifIdPc_d;
    logic [INSTR_W-1:0] ifIdInstr_q, ifIdInstr_d;
    logic               ifIdValid_q, ifIdValid_d;
    logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;

    // Branch beats freeze; counters saturate at all-ones instead of wrapping.
    always_comb begin
        pcPlus      = pc_q + ADDR_W'(PC_STEP);
        pc_d        = pc_q;
        ifIdPc_d    = ifIdPc_q;
        ifIdInstr_d = ifIdInstr_q;
        ifIdValid_d = ifIdValid_q;
        stallCnt_d  = stallCnt_q;
        flushCnt_d  = flushCnt_q;
        if (branch_taken) begin
            pc_d        = branch_addr & ~ADDR_W'(3);
            ifIdPc_d    = '0;
            ifIdInstr_d = '0;
            ifIdValid_d = 1'b0;
            if (flushCnt_q != {CNT_W{1'b1}}) begin
                flushCnt_d = flushCnt_q + CNT_W'(1);
            end
        end else if (freeze) begin
            if (stallCnt_q != {CNT_W{1'b1}}) begin
                stallCnt_d = stallCnt_q + CNT_W'(1);
            end
        end else begin
            pc_d        = pcPlus;
            ifIdPc_d    = pcPlus;
            ifIdInstr_d = imem_data;
            ifIdValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ifIdPc_q    <= '0;
            ifIdInstr_q <= '0;
            ifIdValid_q <= 1'b0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            ifIdPc_q    <= ifIdPc_d;
            ifIdInstr_q <= ifIdInstr_d;
            ifIdValid_q <= ifIdValid_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = ifIdPc_q;
    assign if_id_instr = ifIdInstr_q;
    assign if_id_valid = ifIdValid_q;
    assign stall_cnt   = stallCnt_q;
    assign flush_cnt   = flushCnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage ARM core. It sits directly upstream of hazard detection. It owns the PC and drives the instruction-memory address. It freezes on the hazard unit's hazard_Detected output and flushes on a taken branch resolved in EXE. It also keeps saturating stall and flush counters for performance debug.

Parameters:
ADDR_W, 32, PC and instruction-address width
INSTR_W, 32, instruction word width
PC_STEP, 4, byte increment per sequential fetch
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  stall request, driven by hazard_Detected
branch_taken  input  1  taken branch from EXE; redirects PC and flushes IF/ID
branch_addr  input  ADDR_W  branch target from EXE
imem_addr  output  ADDR_W  instruction memory address (= current PC)
imem_data  input  INSTR_W  instruction read combinationally at imem_addr
if_id_pc  output  ADDR_W  PC+PC_STEP of the instruction held in IF/ID
if_id_instr  output  INSTR_W  instruction held in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction, not a bubble
stall_cnt  output  CNT_W  cycles frozen without a branch
flush_cnt  output  CNT_W  taken branches seen

Behaviour:
- Reset (rst=1 at an edge, wins over everything): pc=RESET_PC, if_id_pc=0, if_id_instr=0, if_id_valid=0, stall_cnt=0, flush_cnt=0. Reset asserted mid-freeze or mid-branch discards that activity.
- imem_addr = pc, combinational. imem_data is valid in the same cycle; no wait states.
- PC update, priority order:
  - branch_taken: pc <= {branch_addr[ADDR_W-1:2], 2'b00}. Low bits are forced to zero.
  - else freeze: pc holds.
  - else: pc <= pc + PC_STEP, modulo 2^ADDR_W. 0xFFFFFFFC wraps to 0x00000000.
- IF/ID update, same priority:
  - branch_taken (flush): if_id_instr <= 0 (NOP), if_id_pc <= 0, if_id_valid <= 0.
  - else freeze: all IF/ID fields hold.
  - else: if_id_instr <= imem_data, if_id_pc <= pc + PC_STEP, if_id_valid <= 1.
- branch_taken together with freeze: the branch wins. PC redirects and IF/ID flushes. stall_cnt does not increment; flush_cnt does.
- Fetch latency: instruction at address A appears on if_id_instr one edge after pc==A with no freeze or branch.
- After a branch:
  - the edge-of-branch cycle leaves a bubble in IF/ID;
  - the target instruction reaches IF/ID on the following edge, if not frozen.
- Counters:
  - stall_cnt increments on each edge with freeze=1 and branch_taken=0.
  - flush_cnt increments on each edge with branch_taken=1.
  - Both saturate at all-ones and never wrap.
  - Both clear only on rst.
- All outputs are registered except imem_addr, which is a direct copy of the pc register. There are no combinational paths from inputs to outputs.
- Inputs are sampled only at rising edges. X on freeze or branch_taken during rst=1 must not propagate.

Test Plan:
- Reset then free-run: imem returns 0xE000_0000+addr. After release, pc goes 0,4,8,12. if_id_instr lags by one edge (0xE000_0000, 0xE000_0004, ...). if_id_pc = 4, 8, 12. if_id_valid=1 from the first edge after reset.
- Freeze for 3 cycles at pc=0x10: pc stays 0x10, IF/ID holds the 0x0C instruction, stall_cnt=3. On release, fetch resumes at 0x10 with no duplicate or skip.
- branch_taken with branch_addr=0x103 at pc=0x20: next pc=0x100, if_id_valid=0, if_id_instr=0, flush_cnt=1. The following edge gives the instruction from 0x100 with if_id_pc=0x104.
- branch_taken and freeze both high for 1 cycle: pc goes to the target, IF/ID is flushed, stall_cnt unchanged, flush_cnt+1.
- pc=0xFFFF_FFFC free-running: next pc=0x0000_0000, and if_id_pc=0x0000_0000 for that fetch.
- CNT_W=3, freeze held 10 cycles: stall_cnt reaches 7 and stays 7. Asserting rst mid-freeze clears it to 0 and sets pc=RESET_PC.
